// File: rtl/seg_scan_ctrl.sv
// Four-digit multiplexed 7-segment scanner sharing one external decoder.
// Display values are double-buffered and swapped only at frame end, so a frame never mixes old and new values.
module seg_scan_ctrl #(
  parameter int SLOT_CYCLES  = 100000,
  parameter int BLANK_CYCLES = 1000,
  parameter int LZ_BLANK     = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic [15:0] digits_in,
  input  logic [3:0]  digit_en,
  input  logic        update_req,
  output logic        update_ack,
  output logic [3:0]  dec_nibble,
  input  logic [6:0]  dec_seg,
  output logic [6:0]  seg,
  output logic [3:0]  an,
  output logic        frame_tick
);

  localparam int TW = $clog2(SLOT_CYCLES);
  localparam logic [TW-1:0] TICK_LAST = TW'(SLOT_CYCLES - 1);
  localparam logic [TW-1:0] TICK_BEND = TW'(BLANK_CYCLES - 1);

  typedef enum logic {ST_BLANK, ST_SHOW} state_t;

  state_t          r_state, w_state_nxt;
  logic [TW-1:0]   r_tick;
  logic [1:0]      r_idx;
  logic [3:0][3:0] r_sh_d, r_pd_d;
  logic [3:0]      r_sh_en, r_pd_en;
  logic            r_pd_vld;
  logic [3:0]      r_an, w_an_nxt;
  logic [6:0]      r_seg, w_seg_nxt;
  logic            r_ack, r_ft;

  logic            w_wrap, w_frame_end, w_apply, w_hi_zero;
  logic [3:0]      w_lz, w_vis;

  assign w_wrap      = (r_tick == TICK_LAST);
  assign w_frame_end = w_wrap && (r_idx == 2'd3);
  assign w_apply     = w_frame_end && r_pd_vld;
  assign dec_nibble  = r_sh_d[r_idx];

  // A digit is a leading zero when it and every digit to its left are zero.
  always_comb begin
    w_lz      = '0;
    w_hi_zero = 1'b1;
    for (int i = 3; i >= 1; i--) begin
      w_hi_zero = w_hi_zero && (r_sh_d[i] == 4'h0);
      w_lz[i]   = (LZ_BLANK != 0) && w_hi_zero;
    end
    w_vis = r_sh_en & ~w_lz;
  end

  always_comb begin
    w_state_nxt = r_state;
    w_an_nxt    = 4'b1111;
    w_seg_nxt   = 7'b1111111;
    case (r_state)
      ST_BLANK: if (r_tick == TICK_BEND) w_state_nxt = ST_SHOW;
      ST_SHOW: begin
        if (w_wrap) w_state_nxt = ST_BLANK;
        if (w_vis[r_idx]) begin
          w_an_nxt  = ~(4'b0001 << r_idx);
          w_seg_nxt = dec_seg;
        end
      end
      default: w_state_nxt = ST_BLANK;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state <= ST_BLANK;
      r_tick  <= '0;
      r_idx   <= 2'd0;
      r_an    <= 4'b1111;
      r_seg   <= 7'b1111111;
      r_ack   <= 1'b0;
      r_ft    <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_tick  <= w_wrap ? '0 : r_tick + TW'(1);
      if (w_wrap) r_idx <= r_idx + 2'd1;
      r_an    <= w_an_nxt;
      r_seg   <= w_seg_nxt;
      r_ack   <= w_apply;
      r_ft    <= w_frame_end;
    end
  end

  // A request on the apply cycle refills pending while the old pending value moves to shadow.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_sh_d   <= '0;
      r_sh_en  <= 4'b0001;
      r_pd_d   <= '0;
      r_pd_en  <= 4'b0000;
      r_pd_vld <= 1'b0;
    end else begin
      if (w_apply) begin
        r_sh_d  <= r_pd_d;
        r_sh_en <= r_pd_en;
      end
      if (update_req) begin
        r_pd_d   <= digits_in;
        r_pd_en  <= digit_en;
        r_pd_vld <= 1'b1;
      end else if (w_apply) begin
        r_pd_vld <= 1'b0;
      end
    end
  end

  assign an         = r_an;
  assign seg        = r_seg;
  assign update_ack = r_ack;
  assign frame_tick = r_ft;

endmodule

// File: tb/tb_seg_scan_ctrl.sv
// Directed bench for seg_scan_ctrl with 8-cycle slots, 2-cycle blanking and an ideal hex decoder.
module tb_seg_scan_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic [15:0] digits_in;
  logic [3:0]  digit_en;
  logic        update_req;
  logic        update_ack;
  logic [3:0]  dec_nibble;
  logic [6:0]  dec_seg;
  logic [6:0]  seg;
  logic [3:0]  an;
  logic        frame_tick;

  int checks = 0;
  int errors = 0;
  int acks   = 0;

  localparam logic [6:0] OFF = 7'b1111111;
  localparam logic [3:0] ANX = 4'b1111;

  seg_scan_ctrl #(.SLOT_CYCLES(8), .BLANK_CYCLES(2), .LZ_BLANK(1)) dut (
    .clk(clk), .reset(reset), .digits_in(digits_in), .digit_en(digit_en),
    .update_req(update_req), .update_ack(update_ack), .dec_nibble(dec_nibble),
    .dec_seg(dec_seg), .seg(seg), .an(an), .frame_tick(frame_tick)
  );

  always #5 clk = ~clk;

  // Ideal active-low {a..g} hex decoder.
  always_comb begin
    case (dec_nibble)
      4'h0: dec_seg = 7'b0000001; 4'h1: dec_seg = 7'b1001111;
      4'h2: dec_seg = 7'b0010010; 4'h3: dec_seg = 7'b0000110;
      4'h4: dec_seg = 7'b1001100; 4'h5: dec_seg = 7'b0100100;
      4'h6: dec_seg = 7'b0100000; 4'h7: dec_seg = 7'b0001111;
      4'h8: dec_seg = 7'b0000000; 4'h9: dec_seg = 7'b0000100;
      4'hA: dec_seg = 7'b0001000; 4'hB: dec_seg = 7'b1100000;
      4'hC: dec_seg = 7'b0110001; 4'hD: dec_seg = 7'b1000010;
      4'hE: dec_seg = 7'b0110000; default: dec_seg = 7'b0111000;
    endcase
  end

  task automatic chk(input string tag, input logic [15:0] got, input logic [15:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s got %h expected %h", tag, got, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
    update_req = 1'b0;
  endtask

  // One 32-cycle frame. ea/es give the SHOW-phase an/seg per slot; optional requests
  // are driven before the edge of loop index rc0/rc1 (-1 = none).
  task automatic run_frame(input string nm, input logic [3:0][3:0] ea, input logic [3:0][6:0] es,
                           input logic exp_ack,
                           input int rc0, input logic [15:0] rd0, input logic [3:0] re0,
                           input int rc1, input logic [15:0] rd1, input logic [3:0] re1);
    for (int c = 0; c < 32; c++) begin
      if (c == rc0) begin update_req = 1'b1; digits_in = rd0; digit_en = re0; end
      if (c == rc1) begin update_req = 1'b1; digits_in = rd1; digit_en = re1; end
      step();
      if (update_ack) acks++;
      if ((c % 8) < 2) begin
        chk({nm, " blank an"}, 16'(an), 16'(ANX));
        chk({nm, " blank seg"}, 16'(seg), 16'(OFF));
      end else begin
        chk($sformatf("%s slot%0d an", nm, c / 8), 16'(an), 16'(ea[c / 8]));
        chk($sformatf("%s slot%0d seg", nm, c / 8), 16'(seg), 16'(es[c / 8]));
      end
      chk({nm, " frame_tick"}, 16'(frame_tick), 16'(c == 31));
      chk({nm, " update_ack"}, 16'(update_ack), 16'((c == 31) && exp_ack));
    end
  endtask

  initial begin
    reset = 1'b1; digits_in = 16'h0; digit_en = 4'h0; update_req = 1'b0;
    repeat (3) step();
    chk("rst an", 16'(an), 16'(ANX));
    chk("rst seg", 16'(seg), 16'(OFF));
    chk("rst ack", 16'(update_ack), 16'd0);
    chk("rst ftick", 16'(frame_tick), 16'd0);
    chk("rst nibble", 16'(dec_nibble), 16'd0);
    reset = 1'b0;

    // Frame 0: reset contents, only digit 0 shows "0".
    run_frame("f0", {4'b1111, 4'b1111, 4'b1111, 4'b1110}, {OFF, OFF, OFF, 7'b0000001}, 1'b0,
              -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    // Frame 1: request 1234 arrives, display unchanged until frame end.
    run_frame("f1", {4'b1111, 4'b1111, 4'b1111, 4'b1110}, {OFF, OFF, OFF, 7'b0000001}, 1'b1,
              5, 16'h1234, 4'b1111, -1, 16'h0, 4'h0);
    // Frame 2: basic scan of 1234; request 0050.
    run_frame("f2", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
              {7'b1001111, 7'b0010010, 7'b0000110, 7'b1001100}, 1'b1,
              20, 16'h0050, 4'b1111, -1, 16'h0, 4'h0);
    // Frame 3: leading zeros; 1111 requested at idx 1, 2222 on the apply cycle.
    acks = 0;
    run_frame("f3", {4'b1111, 4'b1111, 4'b1101, 4'b1110}, {OFF, OFF, 7'b0100100, 7'b0000001}, 1'b1,
              10, 16'h1111, 4'b1111, 31, 16'h2222, 4'b1111);
    run_frame("f4", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
              {7'b1001111, 7'b1001111, 7'b1001111, 7'b1001111}, 1'b1,
              -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    run_frame("f5", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
              {7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010}, 1'b0,
              -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);
    chk("ack count", 16'(acks), 16'd2);
    // Frame 6: request 8888 with enables 0101; frame 7 shows digits 0 and 2 only.
    run_frame("f6", {4'b0111, 4'b1011, 4'b1101, 4'b1110},
              {7'b0010010, 7'b0010010, 7'b0010010, 7'b0010010}, 1'b1,
              3, 16'h8888, 4'b0101, -1, 16'h0, 4'h0);
    run_frame("f7", {4'b1111, 4'b1011, 4'b1111, 4'b1110},
              {OFF, 7'b0000000, OFF, 7'b0000000}, 1'b0,
              -1, 16'h0, 4'h0, -1, 16'h0, 4'h0);

    // Reset in the middle of digit 2's SHOW phase (idx=2, tick=5).
    repeat (21) step();
    chk("pre-rst an", 16'(an), 16'(4'b1011));
    chk("pre-rst nibble", 16'(dec_nibble), 16'h8);
    reset = 1'b1;
    step();
    chk("midrst an", 16'(an), 16'(ANX));
    chk("midrst seg", 16'(seg), 16'(OFF));
    chk("midrst nibble", 16'(dec_nibble), 16'h0);
    chk("midrst ftick", 16'(frame_tick), 16'd0);
    reset = 1'b0;
    step();
    chk("restart c1 an", 16'(an), 16'(ANX));
    step();
    chk("restart c2 an", 16'(an), 16'(ANX));
    step();
    chk("restart c3 an", 16'(an), 16'(4'b1110));
    chk("restart c3 seg", 16'(seg), 16'(7'b0000001));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
